// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson (twisted-ring) sequence generator:
// phase index <-> code mapping and width limits.
package johnson_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 16;
    localparam int MAX_N     = 2 * MAX_WIDTH;

    // Johnson code of phase k for a ring of 'width' bits. Phases below width
    // pack k ones at the LSBs; later phases pack 2*width-k ones at the MSBs.
    function automatic logic [MAX_WIDTH-1:0] jc_from_idx(input int k, input int width);
        logic [MAX_WIDTH-1:0] code;
        code = {MAX_WIDTH{1'b0}};
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i >= width) begin
                code[i] = 1'b0;
            end else if (k < width) begin
                code[i] = (i < k);
            end else begin
                code[i] = (i >= (k - width));
            end
        end
        return code;
    endfunction

    // Reverse mapping: returns {legal, idx[4:0]}. An illegal code gives all zeros.
    function automatic logic [5:0] jc_to_idx(input logic [MAX_WIDTH-1:0] q, input int width);
        logic [5:0] res;
        res = 6'b000000;
        for (int k = 0; k < MAX_N; k++) begin
            res = ((k < 2 * width) && (jc_from_idx(k, width) == q)) ? {1'b1, 5'(k)} : res;
        end
        return res;
    endfunction

    // True when q is one of the 2*width valid Johnson codes.
    function automatic logic jc_legal(input logic [MAX_WIDTH-1:0] q, input int width);
        return (jc_to_idx(q, width) != 6'b000000);
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson decode: code -> phase index, one-hot phase, legality.
// Illegal codes decode to idx=0 and an all-zero one-hot.
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0]              q,
    output logic [$clog2(2*WIDTH)-1:0]    idx,
    output logic [2*WIDTH-1:0]            onehot,
    output logic                          legal
);

    localparam int N    = 2 * WIDTH;
    localparam int IDXW = $clog2(2 * WIDTH);

    logic [5:0] res_s;

    assign res_s = jc_to_idx(MAX_WIDTH'(q), WIDTH);
    assign legal = res_s[5];
    assign idx   = IDXW'(res_s[4:0]);

    // One-hot phase decode, MSB = phase 0.
    always_comb begin
        onehot = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            onehot[i] = legal & (idx == IDXW'(N - 1 - i));
        end
    end

endmodule

// File: rtl/johnson_seq_gen.sv
// Parametrised Johnson sequence generator with aligned one-hot phase decode,
// up/down stepping, clear, indexed load, wrap pulse and sticky error flag.
module johnson_seq_gen
    import johnson_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int INIT_IDX = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          dir,
    input  logic                          clr,
    input  logic                          load,
    input  logic [$clog2(2*WIDTH)-1:0]    load_idx,
    output logic [WIDTH-1:0]              q,
    output logic [$clog2(2*WIDTH)-1:0]    idx,
    output logic [2*WIDTH-1:0]            onehot,
    output logic                          wrap,
    output logic                          err
);

    localparam int N    = 2 * WIDTH;
    localparam int IDXW = $clog2(2 * WIDTH);

    localparam logic [IDXW-1:0]  LAST_IDX   = IDXW'(N - 1);
    localparam logic [WIDTH-1:0] INIT_Q     = WIDTH'(jc_from_idx(INIT_IDX, WIDTH));
    localparam logic [IDXW-1:0]  INIT_IDX_V = IDXW'(INIT_IDX);
    localparam logic [N-1:0]     INIT_OH    = {{(N-1){1'b0}}, 1'b1} << (N - 1 - INIT_IDX);

    logic [WIDTH-1:0] q_r;
    logic [IDXW-1:0]  idx_r;
    logic [N-1:0]     onehot_r;
    logic             wrap_r;
    logic             err_r;

    logic [WIDTH-1:0] q_nxt_s;
    logic [WIDTH-1:0] ld_code_s;
    logic [WIDTH-1:0] step_code_s;
    logic             wrap_nxt_s;
    logic             err_nxt_s;
    logic             cur_legal_s;
    logic             ld_bad_s;
    logic [IDXW-1:0]  nxt_idx_s;
    logic [N-1:0]     nxt_oh_s;
    logic             nxt_legal_s;

    assign cur_legal_s = jc_legal(MAX_WIDTH'(q_r), WIDTH);
    assign ld_code_s   = WIDTH'(jc_from_idx(int'(load_idx), WIDTH));
    assign ld_bad_s    = ({1'b0, load_idx} > {1'b0, LAST_IDX});
    assign step_code_s = dir ? {~q_r[0], q_r[WIDTH-1:1]}
                             : {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};

    // Next-state priority: clr > load > illegal recovery > en step > hold.
    always_comb begin
        q_nxt_s    = q_r;
        wrap_nxt_s = 1'b0;
        err_nxt_s  = err_r;
        if (clr) begin
            q_nxt_s   = {WIDTH{1'b0}};
            err_nxt_s = 1'b0;
        end else if (load) begin
            if (ld_bad_s) begin
                q_nxt_s   = {WIDTH{1'b0}};
                err_nxt_s = 1'b1;
            end else begin
                q_nxt_s   = ld_code_s;
            end
        end else if (!cur_legal_s) begin
            q_nxt_s   = {WIDTH{1'b0}};
            err_nxt_s = 1'b1;
        end else if (en) begin
            q_nxt_s    = step_code_s;
            wrap_nxt_s = dir ? (idx_r == {IDXW{1'b0}}) : (idx_r == LAST_IDX);
        end else begin
            q_nxt_s    = q_r;
        end
    end

    // Decode the next state so idx/onehot register on the same edge as q.
    johnson_decode #(.WIDTH(WIDTH)) u_decode (
        .q      (q_nxt_s),
        .idx    (nxt_idx_s),
        .onehot (nxt_oh_s),
        .legal  (nxt_legal_s)
    );

    // State and output registers; an illegal next code also flags err defensively.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r      <= INIT_Q;
            idx_r    <= INIT_IDX_V;
            onehot_r <= INIT_OH;
            wrap_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            q_r      <= q_nxt_s;
            idx_r    <= nxt_idx_s;
            onehot_r <= nxt_oh_s;
            wrap_r   <= wrap_nxt_s;
            err_r    <= err_nxt_s | ~nxt_legal_s;
        end
    end

    assign q      = q_r;
    assign idx    = idx_r;
    assign onehot = onehot_r;
    assign wrap   = wrap_r;
    assign err    = err_r;

endmodule

// File: tb/tb_johnson_seq_gen.sv
// Directed self-checking bench for johnson_seq_gen: WIDTH=3 main instance,
// WIDTH=3/INIT_IDX=3 for async reset, WIDTH=8 for the full-cycle regression.
module tb_johnson_seq_gen;

    logic clk;
    int   n_cmp;
    int   n_err;

    // WIDTH=3, INIT_IDX=0
    logic       rst0, en0, dir0, clr0, load0;
    logic [2:0] lidx0, q0, idx0;
    logic [5:0] oh0;
    logic       wrap0, err0;

    // WIDTH=3, INIT_IDX=3
    logic       rst1, en1;
    logic [2:0] q1, idx1;
    logic [5:0] oh1;
    logic       wrap1, err1;

    // WIDTH=8, INIT_IDX=0
    logic        en2;
    logic [7:0]  q2;
    logic [3:0]  idx2;
    logic [15:0] oh2;
    logic        wrap2, err2;

    johnson_seq_gen #(.WIDTH(3), .INIT_IDX(0)) dut0 (
        .clk(clk), .rst(rst0), .en(en0), .dir(dir0), .clr(clr0), .load(load0),
        .load_idx(lidx0), .q(q0), .idx(idx0), .onehot(oh0), .wrap(wrap0), .err(err0)
    );

    johnson_seq_gen #(.WIDTH(3), .INIT_IDX(3)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .dir(1'b0), .clr(1'b0), .load(1'b0),
        .load_idx(3'd0), .q(q1), .idx(idx1), .onehot(oh1), .wrap(wrap1), .err(err1)
    );

    johnson_seq_gen #(.WIDTH(8), .INIT_IDX(0)) dut2 (
        .clk(clk), .rst(rst0), .en(en2), .dir(1'b0), .clr(1'b0), .load(1'b0),
        .load_idx(4'd0), .q(q2), .idx(idx2), .onehot(oh2), .wrap(wrap2), .err(err2)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog against a stuck run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] up_q  [7];
    logic [5:0] up_oh [7];
    logic [2:0] dn_q  [3];
    int         wcnt;

    initial begin
        n_cmp = 0; n_err = 0;
        up_q  = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000, 3'b001};
        up_oh = '{6'b010000, 6'b001000, 6'b000100, 6'b000010, 6'b000001, 6'b100000, 6'b010000};
        dn_q  = '{3'b001, 3'b000, 3'b100};

        rst0 = 1'b1; rst1 = 1'b1;
        en0 = 1'b0; dir0 = 1'b0; clr0 = 1'b0; load0 = 1'b0; lidx0 = 3'd0;
        en1 = 1'b0; en2 = 1'b0;
        #12;
        chk("rst_q",    32'(q0),    32'b000);
        chk("rst_idx",  32'(idx0),  32'd0);
        chk("rst_oh",   32'(oh0),   32'b100000);
        chk("rst_wrap", 32'(wrap0), 32'd0);
        chk("rst_err",  32'(err0),  32'd0);
        chk("rst1_q",   32'(q1),    32'b111);
        chk("rst1_oh",  32'(oh1),   32'b000100);
        rst0 = 1'b0; rst1 = 1'b0;

        // Forward run through the wrap and one step beyond.
        en0 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("up_q%0d", i),    32'(q0),    32'(up_q[i]));
            chk($sformatf("up_oh%0d", i),   32'(oh0),   32'(up_oh[i]));
            chk($sformatf("up_wrap%0d", i), 32'(wrap0), (i == 5) ? 32'd1 : 32'd0);
        end

        // Load phase 2, then step down three times across the wrap.
        en0 = 1'b0; load0 = 1'b1; lidx0 = 3'd2;
        tick();
        chk("ld2_q",    32'(q0),    32'b011);
        chk("ld2_idx",  32'(idx0),  32'd2);
        chk("ld2_wrap", 32'(wrap0), 32'd0);
        load0 = 1'b0; dir0 = 1'b1; en0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("dn_q%0d", i),    32'(q0),    32'(dn_q[i]));
            chk($sformatf("dn_wrap%0d", i), 32'(wrap0), (i == 2) ? 32'd1 : 32'd0);
        end
        chk("dn_idx_end", 32'(idx0), 32'd5);

        // clr beats load beats en.
        dir0 = 1'b0; load0 = 1'b1; lidx0 = 3'd4; clr0 = 1'b1;
        tick();
        chk("pri_q",   32'(q0),   32'b000);
        chk("pri_idx", 32'(idx0), 32'd0);
        chk("pri_err", 32'(err0), 32'd0);
        clr0 = 1'b0; en0 = 1'b0;
        tick();
        chk("ld4_q",    32'(q0),    32'b110);
        chk("ld4_idx",  32'(idx0),  32'd4);
        chk("ld4_oh",   32'(oh0),   32'b000010);
        chk("ld4_wrap", 32'(wrap0), 32'd0);

        // Out-of-range load: phase 0 plus sticky err.
        lidx0 = 3'd6;
        tick();
        chk("bad_q",    32'(q0),    32'b000);
        chk("bad_idx",  32'(idx0),  32'd0);
        chk("bad_err",  32'(err0),  32'd1);
        load0 = 1'b0; en0 = 1'b1;
        repeat (10) tick();
        chk("stk_err", 32'(err0), 32'd1);
        chk("stk_q",   32'(q0),   32'b110);
        clr0 = 1'b1; en0 = 1'b0;
        tick();
        chk("clr_err", 32'(err0), 32'd0);
        chk("clr_q",   32'(q0),   32'b000);

        // Direction change takes effect on the very next step (round trip).
        clr0 = 1'b0; en0 = 1'b1; dir0 = 1'b0;
        tick();
        chk("rt_up", 32'(q0), 32'b001);
        dir0 = 1'b1;
        tick();
        chk("rt_dn",   32'(q0),    32'b000);
        chk("rt_wrap", 32'(wrap0), 32'd0);

        // Illegal code 010 with en=0: recovers to phase 0 and sets err.
        en0 = 1'b0; dir0 = 1'b0;
        force dut0.q_r = 3'b010;
        tick();
        chk("ill_oh",   32'(oh0),   32'b100000);
        chk("ill_idx",  32'(idx0),  32'd0);
        chk("ill_err",  32'(err0),  32'd1);
        chk("ill_wrap", 32'(wrap0), 32'd0);
        release dut0.q_r;
        clr0 = 1'b1;
        tick();
        chk("ill_clr_q",   32'(q0),   32'b000);
        chk("ill_clr_err", 32'(err0), 32'd0);
        clr0 = 1'b0;

        // Async reset mid-cycle on the INIT_IDX=3 instance.
        en1 = 1'b1;
        tick();
        tick();
        chk("i3_run_q", 32'(q1), 32'b100);
        #3 rst1 = 1'b1;
        #1;
        chk("i3_arst_q",   32'(q1),   32'b111);
        chk("i3_arst_oh",  32'(oh1),  32'b000100);
        chk("i3_arst_idx", 32'(idx1), 32'd3);
        rst1 = 1'b0; en1 = 1'b0;

        // WIDTH=8: 16 up steps return to the start with exactly one wrap.
        wcnt = 0;
        en2 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (wrap2) wcnt++;
            if (i == 8) chk("w8_mid_q", 32'(q2), 32'hFF);
        end
        en2 = 1'b0;
        chk("w8_end_q",  32'(q2),  32'h00);
        chk("w8_end_oh", 32'(oh2), 32'h8000);
        chk("w8_wraps",  32'(wcnt), 32'd1);
        chk("w8_err",    32'(err2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
